// File: rtl/mem_stage_pkg.sv
// Shared op encodings, latch structures and helpers for the MEM pipeline stage.
package mem_stage_pkg;

   localparam int FROM_WB_TO_MEM_WIDTH = 32;
   localparam logic [15:0] BUS_CANARY_VALUE = 16'hC0DE;

   typedef enum logic [4:0] {
      OP_NOP = 5'd0,
      OP_ADD = 5'd1,
      OP_LB  = 5'd2,
      OP_LH  = 5'd3,
      OP_LW  = 5'd4,
      OP_LBU = 5'd5,
      OP_LHU = 5'd6,
      OP_SB  = 5'd7,
      OP_SH  = 5'd8,
      OP_SW  = 5'd9
   } op_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      op_t         op_i;
      logic [31:0] inst_count;
      logic [31:0] aluout;
      logic [31:0] rs2_val;
      logic [4:0]  rd;
      logic        wr_reg;
      logic [3:0]  type_i;
      logic        valid;
      logic [15:0] bus_canary;
   } agex_latch_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      op_t         op_i;
      logic [31:0] inst_count;
      logic [31:0] aluout;
      logic [4:0]  rd;
      logic        wr_reg;
      logic [3:0]  type_i;
      logic [15:0] bus_canary;
   } mem_latch_t;

   typedef struct packed {
      logic       wr_reg_busy;
      logic [4:0] rd;
   } mem_to_de_t;

   typedef struct packed {
      logic        wr_reg_busy;
      logic [4:0]  rd;
      logic [31:0] result;
   } mem_to_agex_t;

   function automatic logic is_load(op_t op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   function automatic logic is_store(op_t op);
      case (op)
         OP_SB, OP_SH, OP_SW: return 1'b1;
         default:             return 1'b0;
      endcase
   endfunction

   // Word ops need a 4-byte aligned address, half ops a 2-byte aligned one.
   function automatic logic is_misaligned(op_t op, logic [1:0] off);
      case (op)
         OP_LW, OP_SW:         return (off != 2'b00);
         OP_LH, OP_LHU, OP_SH: return off[0];
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-latch bundle between AGEX, MEM, DE and WB as seen by the MEM stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   agex_latch_t                     from_AGEX_latch;
   logic [FROM_WB_TO_MEM_WIDTH-1:0] from_WB_to_MEM;
   mem_latch_t                      from_MEM_latch;
   mem_to_de_t                      from_MEM_to_DE;
   mem_to_agex_t                    from_MEM_to_AGEX;

   modport master (
      output from_AGEX_latch,
      output from_WB_to_MEM,
      input  from_MEM_latch,
      input  from_MEM_to_DE,
      input  from_MEM_to_AGEX
   );

   modport slave (
      input  from_AGEX_latch,
      input  from_WB_to_MEM,
      output from_MEM_latch,
      output from_MEM_to_DE,
      output from_MEM_to_AGEX
   );

endinterface

// File: rtl/mem_stage_dmem_sp.sv
// Single-port-style data memory: asynchronous read, byte-enabled synchronous write.
module dmem_sp #(
   parameter int DMEM_ADDR_BITS = 10,
   parameter     DMEM_INIT_FILE = ""
) (
   input  logic                      clk,
   input  logic [3:0]                we,
   input  logic [DMEM_ADDR_BITS-1:0] waddr,
   input  logic [DMEM_ADDR_BITS-1:0] raddr,
   input  logic [31:0]               wdata,
   output logic [31:0]               rdata
);

   logic [31:0] mem_r [0:(2**DMEM_ADDR_BITS)-1];

   // Byte-lane write port.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: loads/stores against local data memory, MEM latch, hazard/forward outputs.
// Define MEM_MISALIGN_CHECK_EN to suppress misaligned accesses and raise misalign_flag.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DMEM_ADDR_BITS = 10,
   parameter     DMEM_INIT_FILE = ""
) (
   input  logic       clk,
   input  logic       reset,
   mem_stage_if.slave bus,
   output logic       misalign_flag
);

   agex_latch_t               ag_s;
   logic [DMEM_ADDR_BITS-1:0] widx_s;
   logic [1:0]                off_s;
   logic                      ld_s;
   logic                      st_s;
   logic                      misalign_s;
   logic                      busy_s;
   logic [31:0]               rdata_s;
   logic [31:0]               result_s;
   logic [3:0]                we_s;
   logic [31:0]               wdata_s;
   mem_latch_t                nxt_s;
   mem_latch_t                latch_r;
   logic [31:0]               load_count;
   logic [31:0]               store_count;
   logic                      misalign_flag_r;
   logic                      unused_s;

   function automatic logic [31:0] load_align(op_t op, logic [31:0] word, logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'd0, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] store_be(op_t op, logic [1:0] off);
      case (op)
         OP_SB:   return 4'b0001 << off;
         OP_SH:   return off[1] ? 4'b1100 : 4'b0011;
         OP_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicate narrow data into every lane; the byte enables pick the real one.
   function automatic logic [31:0] store_data(op_t op, logic [31:0] rs2);
      case (op)
         OP_SB:   return {4{rs2[7:0]}};
         OP_SH:   return {2{rs2[15:0]}};
         default: return rs2;
      endcase
   endfunction

   assign ag_s     = bus.from_AGEX_latch;
   assign widx_s   = ag_s.aluout[DMEM_ADDR_BITS+1:2];
   assign off_s    = ag_s.aluout[1:0];
   assign unused_s = ^{bus.from_WB_to_MEM, ag_s.aluout[31:DMEM_ADDR_BITS+2]};

   dmem_sp #(
      .DMEM_ADDR_BITS (DMEM_ADDR_BITS),
      .DMEM_INIT_FILE (DMEM_INIT_FILE)
   ) u_dmem (
      .clk   (clk),
      .we    (we_s),
      .waddr (widx_s),
      .raddr (widx_s),
      .wdata (wdata_s),
      .rdata (rdata_s)
   );

   // Decode, load result selection and store lane enables.
   always_comb begin
      ld_s = is_load(ag_s.op_i);
      st_s = is_store(ag_s.op_i);
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_s = ag_s.valid & is_misaligned(ag_s.op_i, off_s);
`else
      misalign_s = 1'b0;
`endif
      if (ld_s && misalign_s) begin
         result_s = 32'd0;
      end else if (ld_s) begin
         result_s = load_align(ag_s.op_i, rdata_s, off_s);
      end else begin
         result_s = ag_s.aluout;
      end
      wdata_s = store_data(ag_s.op_i, ag_s.rs2_val);
      // Reset is async, so it must also veto the write on the edge it overlaps.
      if (ag_s.valid && st_s && !misalign_s && !reset) begin
         we_s = store_be(ag_s.op_i, off_s);
      end else begin
         we_s = 4'b0000;
      end
   end

   assign busy_s = ag_s.valid & ag_s.wr_reg & (ag_s.rd != 5'd0);

   // Next MEM latch contents; bubbles clear inst/op/wr_reg.
   always_comb begin
      nxt_s            = '0;
      nxt_s.inst       = ag_s.valid ? ag_s.inst : 32'd0;
      nxt_s.pc         = ag_s.pc;
      nxt_s.op_i       = ag_s.valid ? ag_s.op_i : OP_NOP;
      nxt_s.inst_count = ag_s.inst_count;
      nxt_s.aluout     = result_s;
      nxt_s.rd         = ag_s.rd;
      nxt_s.wr_reg     = ag_s.wr_reg & ag_s.valid & ~(ld_s & misalign_s);
      nxt_s.type_i     = ag_s.type_i;
      nxt_s.bus_canary = ag_s.bus_canary;
   end

   // MEM latch and retired load/store counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         latch_r            <= '0;
         latch_r.bus_canary <= BUS_CANARY_VALUE;
         load_count         <= 32'd0;
         store_count        <= 32'd0;
      end else begin
         latch_r <= nxt_s;
         if (ag_s.valid && ld_s) begin
            load_count <= load_count + 32'd1;
         end
         if (ag_s.valid && st_s) begin
            store_count <= store_count + 32'd1;
         end
      end
   end

`ifdef MEM_MISALIGN_CHECK_EN
   // Sticky misaligned-access indicator, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_flag_r <= 1'b0;
      end else if (misalign_s) begin
         misalign_flag_r <= 1'b1;
      end
   end
`else
   assign misalign_flag_r = 1'b0;
`endif

   assign misalign_flag        = misalign_flag_r;
   assign bus.from_MEM_latch   = latch_r;
   assign bus.from_MEM_to_DE   = {busy_s, ag_s.rd};
   assign bus.from_MEM_to_AGEX = {busy_s, ag_s.rd, result_s};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a byte-addressed reference model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int AB         = 10;
   localparam int DMEM_BYTES = 4 << AB;

   logic clk = 1'b0;
   logic reset;
   logic misalign_flag;

   mem_stage_if bus();

   mem_stage #(.DMEM_ADDR_BITS(AB), .DMEM_INIT_FILE("")) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .misalign_flag (misalign_flag)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem_m [DMEM_BYTES];
   logic [31:0] ld_cnt_m;
   logic [31:0] st_cnt_m;
   logic        flag_m;
   mem_latch_t  exp_q;
   int          total = 0;
   int          bad = 0;

   function automatic bit m_is_ld(op_t o);
      return o inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic bit m_is_st(op_t o);
      return o inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic int unsigned acc_size(op_t o);
      if (o inside {OP_LB, OP_LBU, OP_SB}) return 1;
      if (o inside {OP_LH, OP_LHU, OP_SH}) return 2;
      if (o inside {OP_LW, OP_SW}) return 4;
      return 0;
   endfunction

   function automatic bit m_misal(agex_latch_t a);
`ifdef MEM_MISALIGN_CHECK_EN
      return a.valid && acc_size(a.op_i) > 1 && (a.aluout % acc_size(a.op_i)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // Naturally aligned container of the access, read byte by byte.
   function automatic logic [31:0] m_load(agex_latch_t a);
      int unsigned sz   = acc_size(a.op_i);
      int unsigned base = a.aluout % DMEM_BYTES;
      logic [31:0] v    = 32'd0;
      base = base - base % sz;
      for (int i = 0; i < sz; i++) v = v + (32'(mem_m[base + i]) << (8 * i));
      if ((a.op_i == OP_LB || a.op_i == OP_LH) && v >= (32'd1 << (8 * sz - 1)))
         v = v - (32'd1 << (8 * sz));
      return v;
   endfunction

   function automatic void m_store(agex_latch_t a);
      int unsigned sz   = acc_size(a.op_i);
      int unsigned base = a.aluout % DMEM_BYTES;
      base = base - base % sz;
      for (int i = 0; i < sz; i++) mem_m[base + i] = 8'(a.rs2_val >> (8 * i));
   endfunction

   function automatic logic [31:0] m_result(agex_latch_t a);
      if (!m_is_ld(a.op_i)) return a.aluout;
      return m_misal(a) ? 32'd0 : m_load(a);
   endfunction

   function automatic mem_to_agex_t m_fwd(agex_latch_t a);
      mem_to_agex_t f;
      f.wr_reg_busy = a.valid && a.wr_reg && a.rd != 5'd0;
      f.rd          = a.rd;
      f.result      = m_result(a);
      return f;
   endfunction

   function automatic mem_latch_t m_latch(agex_latch_t a);
      mem_latch_t m;
      m.inst       = a.valid ? a.inst : 32'd0;
      m.pc         = a.pc;
      m.op_i       = a.valid ? a.op_i : OP_NOP;
      m.inst_count = a.inst_count;
      m.aluout     = m_result(a);
      m.rd         = a.rd;
      m.wr_reg     = a.valid && a.wr_reg && !(m_is_ld(a.op_i) && m_misal(a));
      m.type_i     = a.type_i;
      m.bus_canary = a.bus_canary;
      return m;
   endfunction

   function automatic agex_latch_t mk(op_t op, logic [31:0] addr, logic [31:0] rs2,
                                      logic [4:0] rd, logic wr, logic v);
      agex_latch_t a;
      a.inst       = $urandom;
      a.pc         = $urandom;
      a.op_i       = op;
      a.inst_count = $urandom;
      a.aluout     = addr;
      a.rs2_val    = rs2;
      a.rd         = rd;
      a.wr_reg     = wr;
      a.type_i     = 4'($urandom);
      a.valid      = v;
      a.bus_canary = BUS_CANARY_VALUE;
      return a;
   endfunction

   task automatic drive(agex_latch_t a);
      bus.from_AGEX_latch = a;
      bus.from_WB_to_MEM  = $urandom;
      @(negedge clk);
   endtask

   // Advance the model across the coming posedge, then step past it.
   task automatic clock_in();
      agex_latch_t a;
      a = bus.from_AGEX_latch;
      if (reset) begin
         exp_q            = '0;
         exp_q.bus_canary = BUS_CANARY_VALUE;
         ld_cnt_m         = 32'd0;
         st_cnt_m         = 32'd0;
         flag_m           = 1'b0;
      end else begin
         exp_q = m_latch(a);
         if (a.valid && m_is_ld(a.op_i)) ld_cnt_m = ld_cnt_m + 32'd1;
         if (a.valid && m_is_st(a.op_i)) begin
            st_cnt_m = st_cnt_m + 32'd1;
            if (!m_misal(a)) m_store(a);
         end
         if (m_misal(a)) flag_m = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      drive(mk(OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
      clock_in();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.from_AGEX_latch = mk(OP_SW, 32'h40, 32'h1, 5'd1, 1'b1, 1'b1);
      bus.from_WB_to_MEM  = '0;
      repeat (2) begin
         @(negedge clk);
         clock_in();
      end
      total++; if (bus.from_MEM_latch !== exp_q) begin bad++; $display("FAIL rst_latch: got %h want %h", bus.from_MEM_latch, exp_q); end
      total++; if (dut.load_count !== 32'd0) begin bad++; $display("FAIL rst_ldcnt: got %h want 0", dut.load_count); end
      total++; if (dut.store_count !== 32'd0) begin bad++; $display("FAIL rst_stcnt: got %h want 0", dut.store_count); end
      total++; if (misalign_flag !== 1'b0) begin bad++; $display("FAIL rst_flag: got %b want 0", misalign_flag); end
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_store();
      drive(mk(OP_SW, 32'h40, 32'h0BADF00D, 5'd0, 1'b0, 1'b1));
      clock_in();
      reset = 1'b1;
      drive(mk(OP_SW, 32'h40, 32'hDEADBEEF, 5'd3, 1'b1, 1'b1));
      clock_in();
      total++; if (bus.from_MEM_latch !== exp_q) begin bad++; $display("FAIL midrst_latch: got %h want %h", bus.from_MEM_latch, exp_q); end
      total++; if (bus.from_MEM_latch.wr_reg !== 1'b0) begin bad++; $display("FAIL midrst_wr: got %b want 0", bus.from_MEM_latch.wr_reg); end
      total++; if (dut.store_count !== 32'd0 || dut.load_count !== 32'd0) begin bad++; $display("FAIL midrst_cnt: got %h/%h want 0/0", dut.store_count, dut.load_count); end
      reset = 1'b0;
      drive(mk(OP_LW, 32'h40, 32'd0, 5'd7, 1'b1, 1'b1));
      total++; if (bus.from_MEM_to_AGEX.result !== 32'h0BADF00D) begin bad++; $display("FAIL midrst_mem: got %h want 0badf00d", bus.from_MEM_to_AGEX.result); end
      clock_in();
      total++; if (bus.from_MEM_latch !== exp_q) begin bad++; $display("FAIL midrst_ld: got %h want %h", bus.from_MEM_latch, exp_q); end
   endtask

   task automatic test_store_load();
      agex_latch_t a;
      pulse_reset();
      drive(mk(OP_SW, 32'h40, 32'h12345678, 5'd0, 1'b0, 1'b1));
      clock_in();
      a = mk(OP_LW, 32'h40, 32'd0, 5'd9, 1'b1, 1'b1);
      drive(a);
      total++; if (bus.from_MEM_to_AGEX !== m_fwd(a)) begin bad++; $display("FAIL sl_fwd: got %h want %h", bus.from_MEM_to_AGEX, m_fwd(a)); end
      clock_in();
      total++; if (bus.from_MEM_latch.aluout !== 32'h12345678 || bus.from_MEM_latch.wr_reg !== 1'b1 || bus.from_MEM_latch.rd !== 5'd9)
         begin bad++; $display("FAIL sl_latch: got %h/%b/%0d want 12345678/1/9", bus.from_MEM_latch.aluout, bus.from_MEM_latch.wr_reg, bus.from_MEM_latch.rd); end
      total++; if (bus.from_MEM_latch !== exp_q) begin bad++; $display("FAIL sl_full: got %h want %h", bus.from_MEM_latch, exp_q); end
      total++; if (dut.store_count !== 32'd1 || dut.load_count !== 32'd1) begin bad++; $display("FAIL sl_cnt: got %0d/%0d want 1/1", dut.store_count, dut.load_count); end
   endtask

   task automatic test_load_ext();
      op_t         ops  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
      logic [31:0] adr  [4] = '{32'h43, 32'h43, 32'h42, 32'h40};
      logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
      drive(mk(OP_SW, 32'h40, 32'h80FF7F01, 5'd0, 1'b0, 1'b1));
      clock_in();
      for (int i = 0; i < 4; i++) begin
         drive(mk(ops[i], adr[i], $urandom, 5'd12, 1'b1, 1'b1));
         total++; if (bus.from_MEM_to_AGEX.result !== want[i]) begin bad++; $display("FAIL ext_%0d: got %h want %h", i, bus.from_MEM_to_AGEX.result, want[i]); end
         clock_in();
         total++; if (bus.from_MEM_latch !== exp_q) begin bad++; $display("FAIL ext_latch_%0d: got %h want %h", i, bus.from_MEM_latch, exp_q); end
      end
   endtask

   task automatic test_store_lanes();
      drive(mk(OP_SW, 32'h40, 32'h0, 5'd0, 1'b0, 1'b1));
      clock_in();
      drive(mk(OP_SB, 32'h41, ($urandom & 32'hFFFFFF00) | 32'hAB, 5'd0, 1'b0, 1'b1));
      clock_in();
      drive(mk(OP_LW, 32'h40, 32'd0, 5'd2, 1'b1, 1'b1));
      total++; if (bus.from_MEM_to_AGEX.result !== 32'h0000AB00) begin bad++; $display("FAIL sb_lane: got %h want 0000ab00", bus.from_MEM_to_AGEX.result); end
      clock_in();
      drive(mk(OP_SH, 32'h42, ($urandom & 32'hFFFF0000) | 32'hCDEF, 5'd0, 1'b0, 1'b1));
      clock_in();
      drive(mk(OP_LW, 32'h40, 32'd0, 5'd2, 1'b1, 1'b1));
      total++; if (bus.from_MEM_to_AGEX.result !== 32'hCDEFAB00) begin bad++; $display("FAIL sh_lane: got %h want cdefab00", bus.from_MEM_to_AGEX.result); end
      clock_in();
   endtask

   task automatic test_bubble();
      agex_latch_t a;
      logic [31:0] st_before;
      st_before = st_cnt_m;
      drive(mk(OP_SW, 32'h40, 32'h55555555, 5'd5, 1'b1, 1'b0));
      total++; if (bus.from_MEM_to_DE !== {1'b0, 5'd5}) begin bad++; $display("FAIL bub_de: got %h want %h", bus.from_MEM_to_DE, {1'b0, 5'd5}); end
      clock_in();
      total++; if (bus.from_MEM_latch.wr_reg !== 1'b0 || bus.from_MEM_latch.op_i !== OP_NOP || bus.from_MEM_latch.inst !== 32'd0)
         begin bad++; $display("FAIL bub_latch: got wr=%b op=%0d inst=%h want 0/0/0", bus.from_MEM_latch.wr_reg, bus.from_MEM_latch.op_i, bus.from_MEM_latch.inst); end
      total++; if (dut.store_count !== st_before) begin bad++; $display("FAIL bub_cnt: got %0d want %0d", dut.store_count, st_before); end
      drive(mk(OP_LW, 32'h40, 32'd0, 5'd1, 1'b1, 1'b1));
      total++; if (bus.from_MEM_to_AGEX.result !== 32'hCDEFAB00) begin bad++; $display("FAIL bub_mem: got %h want cdefab00", bus.from_MEM_to_AGEX.result); end
      clock_in();
      a = mk(OP_ADD, $urandom, $urandom, 5'd0, 1'b1, 1'b1);
      drive(a);
      total++; if (bus.from_MEM_to_DE.wr_reg_busy !== 1'b0 || bus.from_MEM_to_AGEX.result !== a.aluout)
         begin bad++; $display("FAIL add_x0: got busy=%b res=%h want 0/%h", bus.from_MEM_to_DE.wr_reg_busy, bus.from_MEM_to_AGEX.result, a.aluout); end
      clock_in();
      a = mk(OP_ADD, $urandom, $urandom, 5'd3, 1'b1, 1'b1);
      drive(a);
      total++; if (bus.from_MEM_to_DE !== {1'b1, 5'd3}) begin bad++; $display("FAIL add_busy: got %h want %h", bus.from_MEM_to_DE, {1'b1, 5'd3}); end
      clock_in();
      total++; if (bus.from_MEM_latch !== exp_q) begin bad++; $display("FAIL add_latch: got %h want %h", bus.from_MEM_latch, exp_q); end
   endtask

   task automatic test_misalign();
      logic        want_flag;
      logic [31:0] want_word;
`ifdef MEM_MISALIGN_CHECK_EN
      want_flag = 1'b1;
      want_word = 32'h11111111;
`else
      want_flag = 1'b0;
      want_word = 32'h22222222;
`endif
      drive(mk(OP_SW, 32'h40, 32'h11111111, 5'd0, 1'b0, 1'b1));
      clock_in();
      drive(mk(OP_SW, 32'h42, 32'h22222222, 5'd0, 1'b0, 1'b1));
      total++; if (misalign_flag !== 1'b0) begin bad++; $display("FAIL mis_early: got %b want 0", misalign_flag); end
      clock_in();
      total++; if (misalign_flag !== want_flag) begin bad++; $display("FAIL mis_set: got %b want %b", misalign_flag, want_flag); end
      drive(mk(OP_LW, 32'h40, 32'd0, 5'd6, 1'b1, 1'b1));
      total++; if (bus.from_MEM_to_AGEX.result !== want_word) begin bad++; $display("FAIL mis_mem: got %h want %h", bus.from_MEM_to_AGEX.result, want_word); end
      clock_in();
      drive(mk(OP_LW, 32'h41, 32'd0, 5'd4, 1'b1, 1'b1));
      clock_in();
      total++; if (bus.from_MEM_latch !== exp_q) begin bad++; $display("FAIL mis_ld: got %h want %h", bus.from_MEM_latch, exp_q); end
      repeat (3) begin
         drive(mk(OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
         clock_in();
      end
      total++; if (misalign_flag !== want_flag) begin bad++; $display("FAIL mis_hold: got %b want %b", misalign_flag, want_flag); end
      pulse_reset();
      total++; if (misalign_flag !== 1'b0) begin bad++; $display("FAIL mis_clr: got %b want 0", misalign_flag); end
   endtask

   task automatic test_random();
      op_t         ops_all [10] = '{OP_NOP, OP_ADD, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
      agex_latch_t a;
      pulse_reset();
      // Initialise 256 bytes; random upper address bits exercise the wrap.
      for (int w = 0; w < 64; w++) begin
         drive(mk(OP_SW, (32'(w) * 32'd4) | ($urandom & 32'hFFFFF000), $urandom, 5'd0, 1'b0, 1'b1));
         clock_in();
      end
      for (int n = 0; n < 500; n++) begin
         a = mk(ops_all[$urandom_range(0, 9)], $urandom & 32'hFFFFF0FF, $urandom,
                5'($urandom), 1'($urandom), ($urandom_range(0, 9) != 0));
         drive(a);
         total++; if (bus.from_MEM_to_AGEX !== m_fwd(a)) begin bad++; $display("FAIL rnd_fwd %0d: got %h want %h", n, bus.from_MEM_to_AGEX, m_fwd(a)); end
         total++; if (bus.from_MEM_to_DE !== {m_fwd(a).wr_reg_busy, a.rd}) begin bad++; $display("FAIL rnd_de %0d: got %h want %h", n, bus.from_MEM_to_DE, {m_fwd(a).wr_reg_busy, a.rd}); end
         clock_in();
         total++; if (bus.from_MEM_latch !== exp_q) begin bad++; $display("FAIL rnd_latch %0d: got %h want %h", n, bus.from_MEM_latch, exp_q); end
         total++; if (misalign_flag !== flag_m) begin bad++; $display("FAIL rnd_flag %0d: got %b want %b", n, misalign_flag, flag_m); end
      end
      total++; if (dut.load_count !== ld_cnt_m) begin bad++; $display("FAIL rnd_ldcnt: got %0d want %0d", dut.load_count, ld_cnt_m); end
      total++; if (dut.store_count !== st_cnt_m) begin bad++; $display("FAIL rnd_stcnt: got %0d want %0d", dut.store_count, st_cnt_m); end
   endtask

   initial begin
      ld_cnt_m = 32'd0;
      st_cnt_m = 32'd0;
      flag_m   = 1'b0;
      test_reset();
      test_reset_mid_store();
      test_store_load();
      test_load_ext();
      test_store_lanes();
      test_bubble();
      test_misalign();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
